// File: rtl/adpll_pkg.sv
// Shared definitions for the ADPLL configuration host: command encodings,
// sequencer states and programming-port field widths.
package adpll_pkg;

    localparam int unsigned PARAM_W = 3;
    localparam int unsigned VALUE_W = 5;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_RD0   = 2'b01;
    localparam logic [1:0] OP_CLR   = 2'b10;
    localparam logic [1:0] OP_RD1   = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StSettle,
        StResp
    } state_e;

endpackage

// File: rtl/adpll_cfg_host.sv
// Host-side sequencer for the ADPLL programming port: turns write/clear/readback
// commands into pgm/clr strobes or a settled readback, one response per command.
module adpll_cfg_host
    import adpll_pkg::*;
#(
    parameter int unsigned PGM_CYCLES = 2,
    parameter int unsigned SETTLE     = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [1:0]         req_op_i,
    input  logic [PARAM_W-1:0] req_param_i,
    input  logic [VALUE_W-1:0] req_value_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [VALUE_W:0]   rsp_data_o,
    output logic [PARAM_W-1:0] param_sel_o,
    output logic [VALUE_W-1:0] pgm_value_o,
    output logic               pgm_o,
    output logic               clr_o,
    output logic               out_sel_o,
    input  logic [VALUE_W-1:0] dout_i,
    input  logic               sign_i
);

    localparam int unsigned CntMax = (PGM_CYCLES > SETTLE) ? PGM_CYCLES : SETTLE;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] PgmLoad    = CntW'(PGM_CYCLES - 1);
    localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE - 1);

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [VALUE_W:0]   rsp_data_q, rsp_data_d;
    logic [PARAM_W-1:0] param_sel_q, param_sel_d;
    logic [VALUE_W-1:0] pgm_value_q, pgm_value_d;
    logic               pgm_q, pgm_d;
    logic               clr_q, clr_d;
    logic               out_sel_q, out_sel_d;

    // req_ready_q is low in the first cycle after reset even though state is idle.
    logic req_hs;
    assign req_hs = req_valid_i & req_ready_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        rsp_data_d  = rsp_data_q;
        param_sel_d = param_sel_q;
        pgm_value_d = pgm_value_q;
        out_sel_d   = out_sel_q;

        unique case (state_q)
            StIdle: begin
                if (req_hs) begin
                    op_d    = req_op_i;
                    state_d = StSetup;
                    // Port fields are loaded at the handshake so they are valid during setup.
                    if (req_op_i == OP_WRITE) begin
                        param_sel_d = req_param_i;
                        pgm_value_d = req_value_i;
                    end else if (req_op_i[0]) begin
                        out_sel_d = req_op_i[1];
                    end
                end
            end
            StSetup: begin
                if (op_q[0]) begin
                    cnt_d   = SettleLoad;
                    state_d = StSettle;
                end else begin
                    cnt_d   = PgmLoad;
                    state_d = StStrobe;
                end
            end
            StStrobe: begin
                if (cnt_q == '0) begin
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHold: begin
                rsp_data_d = '0;
                state_d    = StResp;
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    rsp_data_d = {sign_i, dout_i};
                    state_d    = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        req_ready_d = (state_d == StIdle);
        rsp_valid_d = (state_d == StResp);
        pgm_d       = (state_d == StStrobe) && (op_q == OP_WRITE);
        clr_d       = (state_d == StStrobe) && (op_q == OP_CLR);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            op_q        <= OP_WRITE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            param_sel_q <= '0;
            pgm_value_q <= '0;
            pgm_q       <= 1'b0;
            clr_q       <= 1'b0;
            out_sel_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            param_sel_q <= param_sel_d;
            pgm_value_q <= pgm_value_d;
            pgm_q       <= pgm_d;
            clr_q       <= clr_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign param_sel_o = param_sel_q;
    assign pgm_value_o = pgm_value_q;
    assign pgm_o       = pgm_q;
    assign clr_o       = clr_q;
    assign out_sel_o   = out_sel_q;

endmodule

// File: tb/tb_adpll_cfg_host.sv
// Bench for adpll_cfg_host: default instance (PGM_CYCLES=2, SETTLE=4) and a
// minimal instance (1, 1), driven from a vector table plus corner-case sequences.
module tb_adpll_cfg_host;
    import adpll_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;
    logic       req_valid;
    logic [1:0] req_op;
    logic [2:0] req_param;
    logic [4:0] req_value;
    logic       rsp_ready;
    logic [4:0] dout;
    logic       sign;

    logic       a_req_ready, a_rsp_valid, a_pgm, a_clr, a_out_sel;
    logic [5:0] a_rsp_data;
    logic [2:0] a_param_sel;
    logic [4:0] a_pgm_value;
    logic       b_req_ready, b_rsp_valid, b_pgm, b_clr, b_out_sel;
    logic [5:0] b_rsp_data;
    logic [2:0] b_param_sel;
    logic [4:0] b_pgm_value;

    logic       o_req_ready, o_rsp_valid, o_pgm, o_clr, o_out_sel;
    logic [5:0] o_rsp_data;
    logic [2:0] o_param_sel;
    logic [4:0] o_pgm_value;

    int errors = 0;
    int checks = 0;
    logic [5:0] sb_q[$];

    always #5 clk = ~clk;

    adpll_cfg_host #(.PGM_CYCLES(2), .SETTLE(4)) u_dut_a (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid & ~sel),
        .req_ready_o (a_req_ready),
        .req_op_i    (req_op),
        .req_param_i (req_param),
        .req_value_i (req_value),
        .rsp_valid_o (a_rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (a_rsp_data),
        .param_sel_o (a_param_sel),
        .pgm_value_o (a_pgm_value),
        .pgm_o       (a_pgm),
        .clr_o       (a_clr),
        .out_sel_o   (a_out_sel),
        .dout_i      (dout),
        .sign_i      (sign)
    );

    adpll_cfg_host #(.PGM_CYCLES(1), .SETTLE(1)) u_dut_b (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid & sel),
        .req_ready_o (b_req_ready),
        .req_op_i    (req_op),
        .req_param_i (req_param),
        .req_value_i (req_value),
        .rsp_valid_o (b_rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (b_rsp_data),
        .param_sel_o (b_param_sel),
        .pgm_value_o (b_pgm_value),
        .pgm_o       (b_pgm),
        .clr_o       (b_clr),
        .out_sel_o   (b_out_sel),
        .dout_i      (dout),
        .sign_i      (sign)
    );

    assign o_req_ready = sel ? b_req_ready : a_req_ready;
    assign o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign o_rsp_data  = sel ? b_rsp_data  : a_rsp_data;
    assign o_param_sel = sel ? b_param_sel : a_param_sel;
    assign o_pgm_value = sel ? b_pgm_value : a_pgm_value;
    assign o_pgm       = sel ? b_pgm       : a_pgm;
    assign o_clr       = sel ? b_clr       : a_clr;
    assign o_out_sel   = sel ? b_out_sel   : a_out_sel;

    typedef struct {
        logic [1:0] op;
        logic [2:0] param;
        logic [4:0] value;
        logic [4:0] dout;
        logic       sign;
        logic       sel;
        int         exp_lat;
        logic [5:0] exp_rsp;
        logic [2:0] exp_psel;
        logic [4:0] exp_pval;
        logic       exp_osel;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!o_req_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!o_req_ready) chk("req_ready_timeout", 64'(o_req_ready), 64'd1);
    endtask

    task automatic pop_chk(input string name, input logic [5:0] act);
        chk({name, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) chk(name, 64'(act), 64'(sb_q.pop_front()));
    endtask

    // Issue one command, then watch it cycle by cycle until its response.
    task automatic run_cmd(input vec_t v, input string tag);
        int          p;
        int          lat;
        int unsigned pmask, cmask, exp_pmask, exp_cmask;
        bit          busy_ready;
        p          = v.sel ? 1 : 2;
        exp_pmask  = (v.op == OP_WRITE) ? (((1 << p) - 1) << 2) : 0;
        exp_cmask  = (v.op == OP_CLR) ? (((1 << p) - 1) << 2) : 0;
        sel        = v.sel;
        dout       = v.dout;
        sign       = v.sign;
        rsp_ready  = 1'b1;
        wait_ready();
        req_op     = v.op;
        req_param  = v.param;
        req_value  = v.value;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        sb_q.push_back(v.exp_rsp);
        chk({tag, "_param_sel"}, 64'(o_param_sel), 64'(v.exp_psel));
        chk({tag, "_pgm_value"}, 64'(o_pgm_value), 64'(v.exp_pval));
        chk({tag, "_out_sel"}, 64'(o_out_sel), 64'(v.exp_osel));
        pmask = 0;
        cmask = 0;
        busy_ready = 1'b0;
        lat = 0;
        for (int k = 1; k < 20 && lat == 0; k++) begin
            if (o_pgm) pmask |= (1 << k);
            if (o_clr) cmask |= (1 << k);
            if (o_req_ready) busy_ready = 1'b1;
            if (o_rsp_valid) begin
                lat = k;
                pop_chk({tag, "_rsp_data"}, o_rsp_data);
            end
            @(posedge clk);
            #1;
        end
        chk({tag, "_rsp_latency"}, 64'(lat), 64'(v.exp_lat));
        chk({tag, "_pgm_cycles"}, 64'(pmask), 64'(exp_pmask));
        chk({tag, "_clr_cycles"}, 64'(cmask), 64'(exp_cmask));
        chk({tag, "_ready_while_busy"}, 64'(busy_ready), 64'd0);
        chk({tag, "_ready_after_rsp"}, 64'(o_req_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stable;
        bit no_rsp;
        int n;
        vec_t v;

        vecs[0] = '{OP_WRITE, 3'd5, 5'h13, 5'h00, 1'b0, 1'b0, 5, 6'h00, 3'd5, 5'h13, 1'b0};
        vecs[1] = '{OP_RD1,   3'd0, 5'h00, 5'h0A, 1'b1, 1'b0, 6, 6'h2A, 3'd5, 5'h13, 1'b1};
        vecs[2] = '{OP_CLR,   3'd1, 5'h1F, 5'h00, 1'b0, 1'b0, 5, 6'h00, 3'd5, 5'h13, 1'b1};
        vecs[3] = '{OP_RD0,   3'd6, 5'h04, 5'h1F, 1'b0, 1'b0, 6, 6'h1F, 3'd5, 5'h13, 1'b0};
        vecs[4] = '{OP_WRITE, 3'd2, 5'h07, 5'h12, 1'b1, 1'b0, 5, 6'h00, 3'd2, 5'h07, 1'b0};
        vecs[5] = '{OP_WRITE, 3'd7, 5'h1F, 5'h00, 1'b0, 1'b1, 4, 6'h00, 3'd7, 5'h1F, 1'b0};
        vecs[6] = '{OP_RD1,   3'd0, 5'h00, 5'h15, 1'b1, 1'b1, 3, 6'h35, 3'd7, 5'h1F, 1'b1};
        vecs[7] = '{OP_CLR,   3'd3, 5'h03, 5'h00, 1'b0, 1'b1, 4, 6'h00, 3'd7, 5'h1F, 1'b1};
        vecs[8] = '{OP_RD0,   3'd0, 5'h00, 5'h00, 1'b1, 1'b1, 3, 6'h20, 3'd7, 5'h1F, 1'b0};

        rst_n = 1'b1;
        sel = 1'b0;
        req_valid = 1'b0;
        req_op = '0;
        req_param = '0;
        req_value = '0;
        rsp_ready = 1'b1;
        dout = '0;
        sign = 1'b0;

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({a_req_ready, a_rsp_valid, a_rsp_data, a_param_sel, a_pgm_value,
                                  a_pgm, a_clr, a_out_sel, b_req_ready, b_rsp_valid, b_rsp_data,
                                  b_param_sel, b_pgm_value, b_pgm, b_clr, b_out_sel}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_low_at_release", 64'(a_req_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("ready_first_cycle", 64'({a_req_ready, b_req_ready}), 64'd3);

        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i], $sformatf("vec%0d", i));
        end

        // Response backpressure on a read, with dout changing after the sample.
        sel = 1'b0;
        rsp_ready = 1'b0;
        dout = 5'h11;
        sign = 1'b0;
        wait_ready();
        req_op = OP_RD0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        sb_q.push_back(6'h11);
        n = 0;
        while (!o_rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_rsp_seen", 64'(o_rsp_valid), 64'd1);
        dout = 5'h05;
        sign = 1'b1;
        req_op = OP_WRITE;
        req_param = 3'd6;
        req_value = 5'h1E;
        req_valid = 1'b1;
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (!(o_rsp_valid && o_rsp_data == 6'h11 && !o_req_ready)) stable = 1'b0;
        end
        chk("bp_stable", 64'(stable), 64'd1);
        pop_chk("bp_rsp_data", o_rsp_data);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_after_hs", 64'({o_rsp_valid, o_req_ready, o_param_sel}), 64'({1'b0, 1'b1, 3'd2}));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        sb_q.push_back(6'h00);
        chk("bp_new_accept", 64'({o_req_ready, o_param_sel, o_pgm_value}),
            64'({1'b0, 3'd6, 5'h1E}));
        n = 0;
        while (!o_rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        pop_chk("bp_write_rsp", o_rsp_data);
        @(posedge clk);
        #1;

        // Reset pulse while the program strobe is high.
        wait_ready();
        req_op = OP_WRITE;
        req_param = 3'd3;
        req_value = 5'h09;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_pgm_before", 64'(a_pgm), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", 64'({a_req_ready, a_rsp_valid, a_rsp_data, a_param_sel,
                                      a_pgm_value, a_pgm, a_clr, a_out_sel}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        no_rsp = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (a_rsp_valid) no_rsp = 1'b0;
        end
        chk("rst_no_rsp", 64'(no_rsp), 64'd1);
        v = '{OP_WRITE, 3'd4, 5'h0A, 5'h00, 1'b0, 1'b0, 5, 6'h00, 3'd4, 5'h0A, 1'b0};
        run_cmd(v, "post_rst");

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adpll_cfg_host.md
# adpll_cfg_host

Host-side configuration sequencer for the ADPLL core's programming port. It accepts parameter-write, clear and readback commands over a valid/ready request channel. It generates the `pgm`/`clr` strobe protocol on `param_sel`/`pgm_value`, steers `out_sel`, samples `dout`/`sign`, and returns one response per command. It sits between an on-chip controller (or scan/SPI front end) and the ADPLL core, in the core's `clk` domain.

## Interface
Parameters:
- `PGM_CYCLES`, 2: width of the `pgm`/`clr` high pulse, in cycles (≥1).
- `SETTLE`, 4: cycles `out_sel` is held before `dout`/`sign` are sampled (≥1).

Ports:
- `clk`  in  1  core clock; the only clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  1  command offered.
- `req_ready`  out  1  command accepted when both `req_valid` and `req_ready` are high.
- `req_op`  in  2  command: 00 write, 01 read bank 0, 11 read bank 1, 10 clear.
- `req_param`  in  3  parameter index; used by write only.
- `req_value`  in  5  parameter value; used by write only.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed when both `rsp_valid` and `rsp_ready` are high.
- `rsp_data`  out  6  `{sign, dout}` for reads; 0 for write and clear.
- `param_sel`  out  3  to core.
- `pgm_value`  out  5  to core.
- `pgm`  out  1  to core; program strobe.
- `clr`  out  1  to core; clear strobe.
- `out_sel`  out  1  to core; readback bank select.
- `dout`  in  5  from core.
- `sign`  in  1  from core.

## Operation
- All outputs are registered.
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `param_sel`=0, `pgm_value`=0, `pgm`=0, `clr`=0, `out_sel`=0. `req_ready` rises in the first cycle after reset release.
- FSM states: IDLE, SETUP, STROBE, HOLD, SETTLE, RESP.
  - IDLE: `req_ready`=1. On a request handshake, latch the command and go to SETUP.
  - SETUP (1 cycle):
    - write: drive `param_sel`/`pgm_value`; go to STROBE.
    - clear: go to STROBE.
    - read: drive `out_sel` = `req_op[1]`; go to SETTLE.
  - STROBE (`PGM_CYCLES` cycles): `pgm`=1 for write, `clr`=1 for clear. Then go to HOLD.
  - HOLD (1 cycle): strobes low, data held. Then go to RESP.
  - SETTLE (`SETTLE` cycles): counter runs. On the last cycle, capture `{sign, dout}` into `rsp_data`. Then go to RESP.
  - RESP: `rsp_valid`=1 and `rsp_data` is stable until the response handshake. Then go to IDLE.
- `param_sel`, `pgm_value` and `out_sel` retain their last driven values after a command completes. Only SETUP of a relevant command changes them.
- `pgm` and `clr` are never high simultaneously and are never high outside STROBE.
- At most one command is in flight. `req_ready`=0 in every state except IDLE.
- The counter is wide enough for max(`PGM_CYCLES`, `SETTLE`) and does not wrap.
- Reset asserted mid-command: asynchronously return to IDLE; `pgm`/`clr`/`rsp_valid` drop immediately; no response is produced for the aborted command.

## Timing
- Handshake in cycle 0 (`req_valid`·`req_ready` at edge 0).
- Write/clear:
  - SETUP in cycle 1.
  - Strobe high in cycles 2 .. 1+`PGM_CYCLES`.
  - HOLD in cycle 2+`PGM_CYCLES`.
  - `rsp_valid` from cycle 3+`PGM_CYCLES`. With defaults, `rsp_valid` is first high in cycle 5.
- Read:
  - `out_sel` valid from cycle 1.
  - Sample at the end of cycle 1+`SETTLE`.
  - `rsp_valid` from cycle 2+`SETTLE`. With defaults, cycle 6.
- `rsp_ready` already high when `rsp_valid` rises: RESP lasts 1 cycle, and `req_ready` is high the following cycle.
- Back-to-back throughput with defaults: one write per 6 cycles, one read per 7 cycles.
- `dout`/`sign` are synchronous to `clk`; no synchronizer is required.

## Structure
- Shared package `adpll_pkg`:
  - op encodings `OP_WRITE`/`OP_RD0`/`OP_CLR`/`OP_RD1`;
  - FSM state enum;
  - `PARAM_W`=3, `VALUE_W`=5.
- Single module with no sub-module; the FSM and the down-counter are inline.

## Test plan
- Write param 5, value 0x13 (defaults) → `param_sel`=5 and `pgm_value`=0x13 from cycle 1; `pgm` high in cycles 2–3 only; `rsp_valid` in cycle 5 with `rsp_data`=0.
- Read bank 1 with core driving `dout`=0x0A, `sign`=1 → `out_sel`=1 from cycle 1; `rsp_data`=0x2A in cycle 6. A change to `dout` after the sample does not alter `rsp_data`.
- Clear → `clr` high in cycles 2–3; `pgm` stays 0; `param_sel`/`pgm_value` unchanged from the previous write.
- Response backpressure: `rsp_ready`=0 for 10 cycles → `rsp_valid` and `rsp_data` stay stable; `req_ready` stays 0; a new `req_valid` is not accepted until after the response handshake.
- `rst_n` pulsed low during STROBE → `pgm` drops asynchronously; all outputs return to reset values; no `rsp_valid` for that command; the next command completes normally.
- `PGM_CYCLES`=1, `SETTLE`=1 → write response in cycle 4, read response in cycle 3; no counter wrap.
